// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, decoded memory op, store lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_SB,
        OP_SH,
        OP_SW
    } op_t;

    // Byte write strobes; halfwords use only addr[1], so odd half addresses align down.
    function automatic logic [3:0] wstrb_for(input op_t op, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (op)
            OP_SB:   strb = 4'b0001 << addr_lo;
            OP_SH:   strb = 4'b0011 << {addr_lo[1], 1'b0};
            OP_SW:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicate store data across all lanes so the strobes alone select the bytes.
    function automatic logic [XLEN-1:0] wdata_for(input op_t op, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] wdata;
        case (op)
            OP_SB:   wdata = {4{data[7:0]}};
            OP_SH:   wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

    function automatic logic is_store(input op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfword at an odd address or word not on a 4-byte boundary.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
            OP_LW, OP_SW:         mis = (addr_lo != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/halfword/word from a load word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  op_t             op,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extension according to the load flavour.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'd0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'd0, half_sel};
            OP_LW:   result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: passes ALU results through, or runs one data-memory transaction per load/store.
// Latency: pass-through 1 cycle; memory op 1 + k cycles where k >= 1 is the memory response delay.
// Backpressure: result held in DONE until writeback_ready; LOAD_STORE_UNIT_MISALIGN_TRAP_EN enables misalign traps.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,

    input  logic             executor_valid,
    output logic             accessor_ready,
    output logic             accessor_valid,
    input  logic             writeback_ready,

    input  logic [REG_W-1:0] executor_rd,
    input  logic [XLEN-1:0]  executor_rd_data,
    input  logic [XLEN-1:0]  executor_mem_addr,
    input  logic             executor_is_lb,
    input  logic             executor_is_lbu,
    input  logic             executor_is_lh,
    input  logic             executor_is_lhu,
    input  logic             executor_is_lw,
    input  logic             executor_is_sb,
    input  logic             executor_is_sh,
    input  logic             executor_is_sw,

    output logic             dmem_ready,
    input  logic             dmem_valid,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic [XLEN-1:0]  dmem_rdata,

    output logic [REG_W-1:0] accessor_rd,
    output logic [XLEN-1:0]  accessor_rd_data,
    output logic             accessor_trap
);

    state_t           state;
    state_t           state_next;
    state_t           accept_target;
    op_t              exec_op;
    op_t              op_q;
    logic [REG_W-1:0] rd_q;
    logic [1:0]       addr_lo_q;
    logic             accept;
    logic             mem_done;
    logic             exec_trap;
    logic [XLEN-1:0]  load_result;

    // Collapse the one-hot op flags into the op enum.
    always_comb begin
        exec_op = OP_NONE;
        if (executor_is_lb)       exec_op = OP_LB;
        else if (executor_is_lbu) exec_op = OP_LBU;
        else if (executor_is_lh)  exec_op = OP_LH;
        else if (executor_is_lhu) exec_op = OP_LHU;
        else if (executor_is_lw)  exec_op = OP_LW;
        else if (executor_is_sb)  exec_op = OP_SB;
        else if (executor_is_sh)  exec_op = OP_SH;
        else if (executor_is_sw)  exec_op = OP_SW;
    end

`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
    assign exec_trap = is_misaligned(exec_op, executor_mem_addr[1:0]);

    // Trap flag follows the accepted result; a completed memory op is never a trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accessor_trap <= 1'b0;
        end else if (accept) begin
            accessor_trap <= exec_trap;
        end else if (mem_done) begin
            accessor_trap <= 1'b0;
        end
    end
`else
    assign exec_trap     = 1'b0;
    assign accessor_trap = 1'b0;
`endif

    assign accept        = executor_valid & accessor_ready;
    assign mem_done      = (state == REQ) & dmem_valid;
    // Trapped ops complete without touching memory.
    assign accept_target = ((exec_op == OP_NONE) || exec_trap) ? DONE : REQ;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: DONE can accept the next result in the same cycle it hands one off.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = accept_target;
            end
            REQ: begin
                if (dmem_valid) state_next = DONE;
            end
            DONE: begin
                if (accept)               state_next = accept_target;
                else if (writeback_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; ready is forced low while reset is held.
    always_comb begin
        accessor_ready = ~reset & ((state == IDLE) | ((state == DONE) & writeback_ready));
        accessor_valid = (state == DONE);
        dmem_ready     = (state == REQ);
    end

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo_q),
        .op      (op_q),
        .result  (load_result)
    );

    // Latch the request at accept; capture the writeback result at accept or memory completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q             <= OP_NONE;
            rd_q             <= '0;
            addr_lo_q        <= '0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_wstrb       <= '0;
            accessor_rd      <= '0;
            accessor_rd_data <= '0;
        end else if (accept) begin
            op_q      <= exec_op;
            rd_q      <= executor_rd;
            addr_lo_q <= executor_mem_addr[1:0];
            if (exec_op == OP_NONE) begin
                accessor_rd      <= executor_rd;
                accessor_rd_data <= (executor_rd == '0) ? '0 : executor_rd_data;
            end else if (exec_trap) begin
                accessor_rd      <= '0;
                accessor_rd_data <= '0;
            end else begin
                // Request fields stay frozen for the whole REQ phase.
                dmem_addr  <= {executor_mem_addr[XLEN-1:2], 2'b00};
                dmem_wstrb <= wstrb_for(exec_op, executor_mem_addr[1:0]);
                dmem_wdata <= wdata_for(exec_op, executor_rd_data);
            end
        end else if (mem_done) begin
            if (is_store(op_q)) begin
                accessor_rd      <= '0;
                accessor_rd_data <= '0;
            end else begin
                accessor_rd      <= rd_q;
                accessor_rd_data <= (rd_q == '0) ? '0 : load_result;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed op table, memory responder, backpressure and reset cases.
// Latency: n/a.
// Backpressure: bench drives writeback_ready directly.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        executor_valid;
    logic        accessor_ready;
    logic        accessor_valid;
    logic        writeback_ready;
    logic [4:0]  executor_rd;
    logic [31:0] executor_rd_data;
    logic [31:0] executor_mem_addr;
    logic [7:0]  op_flags;
    logic        dmem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic [4:0]  accessor_rd;
    logic [31:0] accessor_rd_data;
    logic        accessor_trap;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk               (clk),
        .reset             (reset),
        .executor_valid    (executor_valid),
        .accessor_ready    (accessor_ready),
        .accessor_valid    (accessor_valid),
        .writeback_ready   (writeback_ready),
        .executor_rd       (executor_rd),
        .executor_rd_data  (executor_rd_data),
        .executor_mem_addr (executor_mem_addr),
        .executor_is_lb    (op_flags[7]),
        .executor_is_lbu   (op_flags[6]),
        .executor_is_lh    (op_flags[5]),
        .executor_is_lhu   (op_flags[4]),
        .executor_is_lw    (op_flags[3]),
        .executor_is_sb    (op_flags[2]),
        .executor_is_sh    (op_flags[1]),
        .executor_is_sw    (op_flags[0]),
        .dmem_ready        (dmem_ready),
        .dmem_valid        (dmem_valid),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_wstrb        (dmem_wstrb),
        .dmem_rdata        (dmem_rdata),
        .accessor_rd       (accessor_rd),
        .accessor_rd_data  (accessor_rd_data),
        .accessor_trap     (accessor_trap)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        trap;
    } exp_t;

    typedef struct {
        logic [7:0]  flags;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          mwait;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_trap;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic        is_mem;
    } vec_t;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    exp_t        sb[$];
    exp_t        mon_exp;
    vec_t        vecs[$];

    // Memory responder controls.
    int          mem_wait  = 0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] exp_addr  = '0;
    logic [3:0]  exp_strb  = '0;
    logic [31:0] exp_wdata = '0;
    int          req_cnt   = 0;
    int          req_seen  = 0;

    assign dmem_rdata = mem_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] flags, input logic [4:0] rd, input logic [31:0] data,
                                input logic [31:0] addr, input logic [31:0] rdata, input int mwait,
                                input logic [4:0] exp_rd, input logic [31:0] exp_data, input logic exp_trap,
                                input logic [31:0] e_addr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                                input logic is_mem);
        vec_t v;
        v.flags = flags; v.rd = rd; v.data = data; v.addr = addr; v.rdata = rdata; v.mwait = mwait;
        v.exp_rd = exp_rd; v.exp_data = exp_data; v.exp_trap = exp_trap;
        v.exp_addr = e_addr; v.exp_strb = e_strb; v.exp_wdata = e_wdata; v.is_mem = is_mem;
        return v;
    endfunction

    // Memory model: answers after mem_wait REQ cycles, checks request fields every REQ cycle.
    always @(negedge clk) begin
        if (dmem_ready) begin
            req_seen++;
            check_eq("dmem_addr", dmem_addr, exp_addr);
            check_eq("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, exp_strb});
            if (exp_strb != 4'd0) check_eq("dmem_wdata", dmem_wdata, exp_wdata);
            dmem_valid = (req_cnt == mem_wait);
            req_cnt++;
        end else begin
            req_cnt    = 0;
            dmem_valid = 1'($urandom_range(0, 1));
        end
    end

    // Result monitor: every handshake on the writeback side pops one expected result.
    always @(negedge clk) begin
        if (!reset && accessor_valid && writeback_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_result", {31'd0, accessor_valid}, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check_eq("res_rd", {27'd0, accessor_rd}, {27'd0, mon_exp.rd});
                check_eq("res_data", accessor_rd_data, mon_exp.data);
                check_eq("res_trap", {31'd0, accessor_trap}, {31'd0, mon_exp.trap});
            end
        end
    end

    task automatic send(input logic [7:0] flags, input logic [4:0] rd, input logic [31:0] data,
                        input logic [31:0] addr, output int waits);
        logic took;
        waits = 0;
        took  = 1'b0;
        op_flags          = flags;
        executor_rd       = rd;
        executor_rd_data  = data;
        executor_mem_addr = addr;
        executor_valid    = 1'b1;
        while (!took) begin
            @(negedge clk);
            took = accessor_ready;
            @(posedge clk);
            #1;
            if (!took) begin
                waits++;
                if (waits > 50) begin
                    check_eq("accept_timeout", {31'd0, took}, 32'd1);
                    took = 1'b1;
                end
            end
        end
        executor_valid = 1'b0;
        op_flags       = 8'h00;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (accessor_valid) break;
            if (lat >= 50) begin
                check_eq("valid_timeout", {31'd0, accessor_valid}, 32'd1);
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   waits;
        int   lat;
        vec_t v;

        reset             = 1'b1;
        executor_valid    = 1'b0;
        writeback_ready   = 1'b1;
        executor_rd       = '0;
        executor_rd_data  = '0;
        executor_mem_addr = '0;
        op_flags          = 8'h00;
        dmem_valid        = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_acc_valid", {31'd0, accessor_valid}, 32'd0);
        check_eq("rst_acc_ready", {31'd0, accessor_ready}, 32'd0);
        check_eq("rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        check_eq("rst_dmem_addr", dmem_addr, 32'd0);
        check_eq("rst_dmem_wdata", dmem_wdata, 32'd0);
        check_eq("rst_dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        check_eq("rst_acc_rd", {27'd0, accessor_rd}, 32'd0);
        check_eq("rst_acc_data", accessor_rd_data, 32'd0);
        check_eq("rst_acc_trap", {31'd0, accessor_trap}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", {31'd0, accessor_ready}, 32'd1);
        @(posedge clk);
        #1;

        //                flags  rd     data           addr        rdata          w  exp_rd exp_data       trap  dmem_addr   strb   wdata          mem
        vecs.push_back(mk(8'h00, 5'd5,  32'h0000_1234, 32'h0,      32'h0,         0, 5'd5,  32'h0000_1234, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0));
        vecs.push_back(mk(8'h80, 5'd3,  32'h0,         32'h103,    32'h80FF_FF11, 2, 5'd3,  32'hFFFF_FF80, 1'b0, 32'h100,    4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(8'h02, 5'd9,  32'hABCD_BEEF, 32'h202,    32'h0,         0, 5'd0,  32'h0,         1'b0, 32'h200,    4'hC, 32'hBEEF_BEEF, 1'b1));
        vecs.push_back(mk(8'h10, 5'd10, 32'h0,         32'h106,    32'h8001_7FFF, 1, 5'd10, 32'h0000_8001, 1'b0, 32'h104,    4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(8'h20, 5'd11, 32'h0,         32'h104,    32'h1234_F00D, 0, 5'd11, 32'hFFFF_F00D, 1'b0, 32'h104,    4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(8'h40, 5'd12, 32'h0,         32'h101,    32'hAABB_CCDD, 0, 5'd12, 32'h0000_00CC, 1'b0, 32'h100,    4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(8'h04, 5'd13, 32'h1234_565A, 32'h301,    32'h0,         1, 5'd0,  32'h0,         1'b0, 32'h300,    4'h2, 32'h5A5A_5A5A, 1'b1));
        vecs.push_back(mk(8'h01, 5'd14, 32'hDEAD_BEEF, 32'h400,    32'h0,         0, 5'd0,  32'h0,         1'b0, 32'h400,    4'hF, 32'hDEAD_BEEF, 1'b1));
        vecs.push_back(mk(8'h08, 5'd0,  32'h0,         32'h408,    32'h1111_2222, 0, 5'd0,  32'h0,         1'b0, 32'h408,    4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(8'h00, 5'd0,  32'h0000_FFFF, 32'h0,      32'h0,         0, 5'd0,  32'h0,         1'b0, 32'h0,      4'h0, 32'h0,         1'b0));
`ifdef LOAD_STORE_UNIT_MISALIGN_TRAP_EN
        vecs.push_back(mk(8'h08, 5'd4,  32'h0,         32'h101,    32'h1234_5678, 0, 5'd0,  32'h0,         1'b1, 32'h0,      4'h0, 32'h0,         1'b0));
        vecs.push_back(mk(8'h20, 5'd15, 32'h0,         32'h10B,    32'hFEDC_0000, 0, 5'd0,  32'h0,         1'b1, 32'h0,      4'h0, 32'h0,         1'b0));
`else
        vecs.push_back(mk(8'h08, 5'd4,  32'h0,         32'h101,    32'h1234_5678, 0, 5'd4,  32'h1234_5678, 1'b0, 32'h100,    4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(8'h20, 5'd15, 32'h0,         32'h10B,    32'hFEDC_0000, 0, 5'd15, 32'hFFFF_FEDC, 1'b0, 32'h108,    4'h0, 32'h0,         1'b1));
`endif

        foreach (vecs[i]) begin
            v         = vecs[i];
            mem_wait  = v.mwait;
            mem_rdata = v.rdata;
            exp_addr  = v.exp_addr;
            exp_strb  = v.exp_strb;
            exp_wdata = v.exp_wdata;
            sb.push_back('{rd: v.exp_rd, data: v.exp_data, trap: v.exp_trap});
            req_seen  = 0;
            send(v.flags, v.rd, v.data, v.addr, waits);
            wait_valid(lat);
            check_eq($sformatf("latency_%0d", i), lat, v.is_mem ? v.mwait + 1 : 0);
            @(posedge clk);
            #1;
            check_eq($sformatf("req_cycles_%0d", i), req_seen, v.is_mem ? v.mwait + 1 : 0);
        end

        // Backpressure: result must sit unchanged in DONE while writeback stalls.
        writeback_ready = 1'b0;
        sb.push_back('{rd: 5'd7, data: 32'h55, trap: 1'b0});
        send(8'h00, 5'd7, 32'h55, 32'h0, waits);
        wait_valid(lat);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'd0, accessor_valid}, 32'd1);
            check_eq("bp_rd", {27'd0, accessor_rd}, 32'd7);
            check_eq("bp_data", accessor_rd_data, 32'h55);
            check_eq("bp_ready", {31'd0, accessor_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        writeback_ready = 1'b1;
        sb.push_back('{rd: 5'd8, data: 32'h88, trap: 1'b0});
        send(8'h00, 5'd8, 32'h88, 32'h0, waits);
        check_eq("b2b_wait_1", waits, 0);
        sb.push_back('{rd: 5'd9, data: 32'h99, trap: 1'b0});
        send(8'h00, 5'd9, 32'h99, 32'h0, waits);
        check_eq("b2b_wait_2", waits, 0);
        wait_valid(lat);
        @(posedge clk);
        #1;

        // Reset in the middle of a memory transaction abandons it.
        mem_wait  = 1000;
        exp_addr  = 32'h500;
        exp_strb  = 4'h0;
        send(8'h08, 5'd6, 32'h0, 32'h500, waits);
        @(negedge clk);
        check_eq("midreq_dmem_ready", {31'd0, dmem_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        check_eq("arst_acc_valid", {31'd0, accessor_valid}, 32'd0);
        check_eq("arst_acc_ready", {31'd0, accessor_ready}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, accessor_ready}, 32'd1);
        check_eq("post_rst_valid", {31'd0, accessor_valid}, 32'd0);
        check_eq("post_rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        @(posedge clk);
        #1;
        sb.push_back('{rd: 5'd21, data: 32'h77, trap: 1'b0});
        send(8'h00, 5'd21, 32'h77, 32'h0, waits);
        wait_valid(lat);
        check_eq("post_rst_latency", lat, 0);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
